seg7_scan_controller: RTL and testbench
=======================================

Name: seg7_scan_controller

Overview:
- Time-multiplexes a single hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Sequences digit index, nibble and decimal point into the decoder, and drives active-low anode enables.
- Inserts guard time between digits to stop ghosting.
- Provides tear-free value loading (applied at frame boundary) and optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 is rightmost/least significant.
- DIGIT_CYCLES, 50000, clock cycles each digit's anode is driven (>=1).
- GUARD_CYCLES, 500, clock cycles all anodes are off before each digit (>=0; 0 means no guard state).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low forces blank idle.
- load  in  1  single-cycle strobe capturing value_in/dp_in into shadow registers.
- value_in  in  4*NUM_DIGITS  nibble i (bits 4i+3:4i) is digit i.
- dp_in  in  NUM_DIGITS  bit i high means digit i decimal point lit.
- lzb_en  in  1  leading-zero blanking enable (level, sampled live).
- hex_out  out  4  nibble to decoder hex input.
- dp_out  out  1  to decoder dp input, active low (0 = lit).
- anode_n  out  NUM_DIGITS  digit enables, active low, at most one low at a time.
- pending  out  1  high while a loaded value awaits frame boundary.
- frame_done  out  1  one-cycle pulse at end of each full scan frame.

Behaviour:
- Reset (async, rst_n=0): anode_n all 1, hex_out 0, dp_out 1, frame_done 0, pending 0, active/shadow value and dp 0, digit index 0, cycle counter 0, state IDLE.
- States: IDLE, GUARD, DRIVE. All outputs registered.
- IDLE: anode_n all 1, hex_out 0, dp_out 1. enable=1 -> GUARD with index 0 (DRIVE directly if GUARD_CYCLES=0).
- GUARD: lasts exactly GUARD_CYCLES cycles. anode_n all 1; hex_out/dp_out already present the digit about to be driven. Then -> DRIVE.
- DRIVE: lasts exactly DIGIT_CYCLES cycles. anode_n[idx]=0 unless digit blanked; then index increments mod NUM_DIGITS -> GUARD (or DRIVE if GUARD_CYCLES=0).
- Frame period: NUM_DIGITS*(GUARD_CYCLES+DIGIT_CYCLES) cycles.
- frame_done asserts for the one cycle that is the last DRIVE cycle of digit NUM_DIGITS-1.
- Frame boundary: entry into the first state (GUARD or DRIVE) of digit 0, including the first entry from IDLE.
  - If pending, active value and dp are copied from shadow and pending clears in that same cycle.
- load: shadow <= value_in/dp_in, pending <= 1 next cycle. load during pending overwrites shadow.
  - load in the same cycle as a frame-boundary apply: apply uses old shadow, new data captured, pending remains 1.
  - load is accepted in every state, including IDLE.
- Leading-zero blanking: digit i (i>=1) is blanked when lzb_en=1 and, for every j in i..NUM_DIGITS-1, nibble j == 0 and dp bit j == 0.
  - Digit 0 is never blanked. A blanked digit keeps anode_n all 1 for its DRIVE slot; timing is unchanged.
- dp_out = ~active_dp[idx] while in GUARD/DRIVE.
- enable falling mid-scan: next cycle -> IDLE, anode_n all 1, index and counter cleared, pending/shadow kept.
- Counter width: clog2(max(DIGIT_CYCLES,GUARD_CYCLES)+1). The counter wraps only via state change.

Test Plan:
- Params 4/8/2, reset then enable=1 with no load -> anode_n stays 1111 for 2 cycles, then 1110 for 8 cycles, 2 cycles 1111, then 1101. hex_out=0, dp_out=1; frame_done pulses every 40 cycles.
- load value_in=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1 until next digit-0 boundary. Then digit 0 shows F, 1 shows A, 2 shows 2 with dp_out=0, 3 shows 1; pending=0.
- lzb_en=1, load 16'h0005, dp_in=0 -> only digit 0 anode ever goes low. Load 16'h0040 -> digits 0,1 lit, digits 2,3 blanked.
- Two loads (16'h1111 then 16'h2222) within one frame -> next frame displays 2222 only. A load coinciding with the boundary cycle keeps pending=1.
- Drop enable during DRIVE of digit 2 -> anode_n=1111 next cycle. Re-enable -> restart at digit 0 after guard.
- Assert rst_n=0 asynchronously mid-DRIVE -> anode_n=1111, pending=0, hex_out=0 immediately without a clock edge. Also set GUARD_CYCLES=0 -> anodes rotate every 8 cycles with no all-off gap.

Source files
------------

// File: rtl/seg7_scan_controller.sv
// Purpose : multiplexes one hex-to-7-segment decoder across NUM_DIGITS common-anode
//           digits with guard gaps, frame-boundary value loading and leading-zero blanking.
// Latency : all outputs registered; a state change appears one cycle after its cause.
// Backpressure: none; load is accepted every cycle and held in a shadow until the frame boundary.
// Ports   : clk, rst_n (async, active low), enable, load, value_in[4N], dp_in[N], lzb_en
//           -> hex_out[4], dp_out (active low), anode_n[N] (active low), pending, frame_done.
module seg7_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lzb_en,
   output logic [3:0]              hex_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   anode_n,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int MAXC = (DIGIT_CYCLES > GUARD_CYCLES) ? DIGIT_CYCLES : GUARD_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int VW   = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [CW-1:0] G_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

   // First state of every digit slot; with no guard time a slot starts straight in DRIVE.
   localparam state_t FIRST = (GUARD_CYCLES > 0) ? GUARD : DRIVE;

   state_t                state, state_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic [VW-1:0]         act_val, shd_val, act_val_nxt;
   logic [NUM_DIGITS-1:0] act_dp, shd_dp, act_dp_nxt;
   logic [NUM_DIGITS-1:0] blank;
   logic [NUM_DIGITS-1:0] anode_nxt;
   logic                  apply;
   logic                  zero_run;

   // Sequencer: cnt counts cycles spent in the current state and restarts on every state change.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt + 1'b1;
      apply     = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
         idx_nxt   = '0;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = FIRST;
               idx_nxt   = '0;
               cnt_nxt   = '0;
               apply     = pending;
            end
            GUARD: begin
               if (cnt == G_LAST) begin
                  state_nxt = DRIVE;
                  cnt_nxt   = '0;
               end
            end
            DRIVE: begin
               if (cnt == D_LAST) begin
                  state_nxt = FIRST;
                  cnt_nxt   = '0;
                  if (idx == I_LAST) begin
                     idx_nxt = '0;
                     apply   = pending;   // entering digit 0 is the frame boundary
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
               idx_nxt   = '0;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign act_val_nxt = apply ? shd_val : act_val;
   assign act_dp_nxt  = apply ? shd_dp  : act_dp;

   // Leading-zero run scanned from the most significant digit down; digit 0 always shows.
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
         zero_run = zero_run & (act_val_nxt[4*j +: 4] == 4'h0) & ~act_dp_nxt[j];
         if (j != 0) blank[j] = lzb_en & zero_run;
      end
   end

   always_comb begin
      anode_nxt = '1;
      if (state_nxt == DRIVE && !blank[idx_nxt]) anode_nxt[idx_nxt] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         act_val    <= '0;
         act_dp     <= '0;
         shd_val    <= '0;
         shd_dp     <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         anode_n    <= '1;
         hex_out    <= 4'h0;
         dp_out     <= 1'b1;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         cnt     <= cnt_nxt;
         act_val <= act_val_nxt;
         act_dp  <= act_dp_nxt;
         // A load coinciding with an apply wins: the apply took the old shadow,
         // the new data still waits for the next boundary.
         if (load) begin
            shd_val <= value_in;
            shd_dp  <= dp_in;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
         frame_done <= (state_nxt == DRIVE) && (idx_nxt == I_LAST) && (cnt_nxt == D_LAST);
         anode_n    <= anode_nxt;
         if (state_nxt == IDLE) begin
            hex_out <= 4'h0;
            dp_out  <= 1'b1;
         end else begin
            // Guard cycles already present the upcoming digit so the decoder settles before the anode turns on.
            hex_out <= act_val_nxt[{idx_nxt, 2'b00} +: 4];
            dp_out  <= ~act_dp_nxt[idx_nxt];
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Purpose : directed bench for seg7_scan_controller (4 digits, 8 drive, 2 guard) plus a no-guard instance.
// Latency : expected per-cycle outputs are queued when stimulus is applied and popped at each falling edge.
// Backpressure: not applicable; the bench drives inputs on the falling edge after sampling.
module tb_seg7_scan_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable, enable2, load, lzb_en;
   logic [15:0] value_in;
   logic [3:0]  dp_in;

   logic [3:0]  hex1, hex2, an1, an2;
   logic        dp1, dp2, pend1, pend2, fd1, fd2;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   seg7_scan_controller #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .GUARD_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value_in(value_in),
      .dp_in(dp_in), .lzb_en(lzb_en), .hex_out(hex1), .dp_out(dp1), .anode_n(an1),
      .pending(pend1), .frame_done(fd1)
   );

   seg7_scan_controller #(.NUM_DIGITS(4), .DIGIT_CYCLES(8), .GUARD_CYCLES(0)) u_nog (
      .clk(clk), .rst_n(rst_n), .enable(enable2), .load(load), .value_in(value_in),
      .dp_in(dp_in), .lzb_en(lzb_en), .hex_out(hex2), .dp_out(dp2), .anode_n(an2),
      .pending(pend2), .frame_done(fd2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // One frame of expected outputs: per digit, g guard cycles then 8 drive cycles.
   task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input bit lzb, input int g);
      exp_t       e;
      logic [3:0] sel;
      bit         blk;
      for (int dg = 0; dg < 4; dg++) begin
         blk = 1'b0;
         if (lzb && dg > 0) begin
            blk = 1'b1;
            for (int j = dg; j < 4; j++)
               if (v[j*4 +: 4] != 4'h0 || d[j]) blk = 1'b0;
         end
         sel = 4'b0001 << dg;
         for (int c = 0; c < g; c++) begin
            e.an = 4'hF; e.hex = v[dg*4 +: 4]; e.dp = ~d[dg]; e.fd = 1'b0;
            exp_q.push_back(e);
         end
         for (int c = 0; c < 8; c++) begin
            e.an  = blk ? 4'hF : ~sel;
            e.hex = v[dg*4 +: 4];
            e.dp  = ~d[dg];
            e.fd  = (dg == 3 && c == 7);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drain(input int n, input bit nog);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk(nog ? "nog_anode" : "anode", nog ? an2  : an1,  e.an);
            chk(nog ? "nog_hex"   : "hex",   nog ? hex2 : hex1, e.hex);
            chk(nog ? "nog_dp"    : "dp",    nog ? dp2  : dp1,  e.dp);
            chk(nog ? "nog_fdone" : "fdone", nog ? fd2  : fd1,  e.fd);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; load = 1'b0;
      lzb_en = 1'b0; value_in = '0; dp_in = '0;
      #12;
      chk("rst_anode", an1, 4'hF);
      chk("rst_hex", hex1, 4'h0);
      chk("rst_dp", dp1, 1'b1);
      chk("rst_pending", pend1, 1'b0);
      chk("rst_fdone", fd1, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("idle_anode", an1, 4'hF);
      enable = 1'b1;

      // Frames A, B: blank value, load 12AF mid-frame B.
      push_frame(16'h0000, 4'b0000, 1'b0, 2);
      drain(40, 1'b0);
      push_frame(16'h0000, 4'b0000, 1'b0, 2);
      drain(15, 1'b0);
      load = 1'b1; value_in = 16'h12AF; dp_in = 4'b0100;
      drain(1, 1'b0);
      load = 1'b0;
      chk("pend_after_load", pend1, 1'b1);
      drain(24, 1'b0);
      chk("pend_before_bnd", pend1, 1'b1);

      // Frame C shows 12AF; Frame D: lzb on, load 0005 mid-frame.
      push_frame(16'h12AF, 4'b0100, 1'b0, 2);
      drain(1, 1'b0);
      chk("pend_applied", pend1, 1'b0);
      drain(39, 1'b0);
      lzb_en = 1'b1;
      push_frame(16'h12AF, 4'b0100, 1'b1, 2);
      drain(5, 1'b0);
      load = 1'b1; value_in = 16'h0005; dp_in = 4'b0000;
      drain(1, 1'b0);
      load = 1'b0;
      drain(34, 1'b0);

      // Frame E: 0005 blanked down to digit 0; load 0040 mid-frame.
      push_frame(16'h0005, 4'b0000, 1'b1, 2);
      drain(10, 1'b0);
      load = 1'b1; value_in = 16'h0040;
      drain(1, 1'b0);
      load = 1'b0;
      drain(29, 1'b0);

      // Frame F shows 0040; Frame G: two loads, the later one must win.
      push_frame(16'h0040, 4'b0000, 1'b1, 2);
      drain(40, 1'b0);
      push_frame(16'h0040, 4'b0000, 1'b1, 2);
      drain(5, 1'b0);
      load = 1'b1; value_in = 16'h1111;
      drain(1, 1'b0);
      load = 1'b0;
      drain(5, 1'b0);
      load = 1'b1; value_in = 16'h2222;
      drain(1, 1'b0);
      load = 1'b0;
      drain(28, 1'b0);

      // Frame H shows 2222; load 3333 mid-frame, then 4444 exactly on the boundary.
      push_frame(16'h2222, 4'b0000, 1'b1, 2);
      drain(10, 1'b0);
      load = 1'b1; value_in = 16'h3333;
      drain(1, 1'b0);
      load = 1'b0;
      drain(29, 1'b0);
      load = 1'b1; value_in = 16'h4444;
      push_frame(16'h3333, 4'b0000, 1'b1, 2);
      drain(1, 1'b0);
      load = 1'b0;
      chk("pend_bnd_load", pend1, 1'b1);
      drain(39, 1'b0);

      // Frame J shows 4444; drop enable during digit 2 drive.
      push_frame(16'h4444, 4'b0000, 1'b1, 2);
      drain(1, 1'b0);
      chk("pend_clear_j", pend1, 1'b0);
      drain(24, 1'b0);
      chk("pre_drop_anode", an1, 4'b1011);
      enable = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("drop_anode", an1, 4'hF);
      chk("drop_hex", hex1, 4'h0);
      chk("drop_dp", dp1, 1'b1);
      enable = 1'b1;
      push_frame(16'h4444, 4'b0000, 1'b1, 2);
      drain(40, 1'b0);

      // Async reset in the middle of a DRIVE slot with a load pending.
      push_frame(16'h4444, 4'b0000, 1'b1, 2);
      drain(3, 1'b0);
      load = 1'b1; value_in = 16'h5678;
      drain(1, 1'b0);
      load = 1'b0;
      chk("pend_pre_rst", pend1, 1'b1);
      drain(1, 1'b0);
      exp_q.delete();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_anode", an1, 4'hF);
      chk("arst_pending", pend1, 1'b0);
      chk("arst_hex", hex1, 4'h0);
      chk("arst_dp", dp1, 1'b1);
      chk("arst_fdone", fd1, 1'b0);

      // No-guard instance: anodes rotate every 8 cycles with no all-off gap.
      enable = 1'b0; lzb_en = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      enable2 = 1'b1;
      push_frame(16'h0000, 4'b0000, 1'b0, 0);
      push_frame(16'h0000, 4'b0000, 1'b0, 0);
      drain(64, 1'b1);
      chk("nog_pending", pend2, 1'b0);
      chk("main_idle_anode", an1, 4'hF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
